// File: rtl/fb_rect_fill.sv
// Rectangle fill engine feeding the framebuffer write port.
// CPU bus glue loads origin, size, colour and command registers. A FILL
// command clips the rectangle to the screen and streams one cell write per
// accepted handshake in row-major order. A SWAP command, on its own or
// after a fill, issues a one-cycle buffer-swap pulse.
module fb_rect_fill #(
    parameter int FB_WIDTH  = 80,
    parameter int FB_HEIGHT = 60,
    parameter int ADDR_W    = 13
) (
    input  logic              CLK_SYS,
    input  logic              RESET,
    input  logic              REG_WE,
    input  logic [2:0]        REG_ADDR,
    input  logic [6:0]        REG_DATA,
    output logic [1:0]        STATUS,
    output logic              FB_WE,
    output logic [ADDR_W-1:0] FB_ADDR,
    output logic [2:0]        FB_DATA,
    input  logic              FB_READY,
    output logic              FB_SWAP
);

    localparam logic [7:0]        FB_W8     = 8'(FB_WIDTH);
    localparam logic [7:0]        FB_H8     = 8'(FB_HEIGHT);
    localparam logic [31:0]       FB_W_BITS = 32'(FB_WIDTH);
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(FB_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_SWAP = 2'd2
    } state_t;

    state_t state_reg;

    // CPU-visible registers
    logic [6:0] x_reg;
    logic [6:0] y_reg;
    logic [6:0] w_reg;
    logic [6:0] h_reg;
    logic [2:0] color_reg;
    logic       overrun_reg;

    // Working copies captured at command start plus the traversal cursor
    logic [6:0]        cur_x_reg;
    logic [6:0]        cur_y_reg;
    logic [6:0]        x_start_reg;
    logic [6:0]        x_last_reg;
    logic [6:0]        y_last_reg;
    logic              swap_pend_reg;
    logic [ADDR_W-1:0] row_base_reg;

    // Registered outputs
    logic              fb_we_reg;
    logic [ADDR_W-1:0] fb_addr_reg;
    logic [2:0]        fb_data_reg;
    logic              fb_swap_reg;

    // Command decode and clipping of the live register values
    logic              cmd_wr;
    logic              cmd_fill;
    logic              cmd_swap;
    logic              cmd_clear;
    logic [7:0]        x_sum;
    logic [7:0]        y_sum;
    logic [7:0]        x_end;
    logic [7:0]        y_end;
    logic              rect_empty;
    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] row_base_start;
    logic [ADDR_W-1:0] start_addr;
    logic              last_cell;

    assign cmd_wr    = REG_WE && (REG_ADDR == 3'd5);
    assign cmd_fill  = REG_DATA[0];
    assign cmd_swap  = REG_DATA[1];
    assign cmd_clear = REG_DATA[6];

    // Sums are one bit wider than the registers so X+W cannot wrap
    assign x_sum = {1'b0, x_reg} + {1'b0, w_reg};
    assign y_sum = {1'b0, y_reg} + {1'b0, h_reg};
    assign x_end = (x_sum > FB_W8) ? FB_W8 : x_sum;
    assign y_end = (y_sum > FB_H8) ? FB_H8 : y_sum;

    assign rect_empty = (w_reg == 7'd0) || (h_reg == 7'd0) ||
                        ({1'b0, x_reg} >= FB_W8) || ({1'b0, y_reg} >= FB_H8);

    assign y_ext = ADDR_W'(y_reg);

    // Starting row base Y*FB_WIDTH built from shifted copies of Y, one per
    // set bit of the constant width; later rows step by FB_WIDTH.
    always_comb begin
        row_base_start = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (FB_W_BITS[i]) begin
                row_base_start = row_base_start + (y_ext << i);
            end
        end
    end

    assign start_addr = row_base_start + ADDR_W'(x_reg);
    assign last_cell  = (cur_x_reg == x_last_reg) && (cur_y_reg == y_last_reg);

    // CPU register file; writes are accepted in every state
    always_ff @(posedge CLK_SYS) begin
        if (RESET) begin
            x_reg     <= '0;
            y_reg     <= '0;
            w_reg     <= '0;
            h_reg     <= '0;
            color_reg <= '0;
        end else if (REG_WE) begin
            case (REG_ADDR)
                3'd0:    x_reg     <= REG_DATA;
                3'd1:    y_reg     <= REG_DATA;
                3'd2:    w_reg     <= REG_DATA;
                3'd3:    h_reg     <= REG_DATA;
                3'd4:    color_reg <= REG_DATA[2:0];
                default: ;
            endcase
        end
    end

    // Control FSM: command acceptance, row-major traversal, swap pulse
    always_ff @(posedge CLK_SYS) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            overrun_reg   <= 1'b0;
            cur_x_reg     <= '0;
            cur_y_reg     <= '0;
            x_start_reg   <= '0;
            x_last_reg    <= '0;
            y_last_reg    <= '0;
            swap_pend_reg <= 1'b0;
            row_base_reg  <= '0;
            fb_we_reg     <= 1'b0;
            fb_addr_reg   <= '0;
            fb_data_reg   <= '0;
            fb_swap_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_wr) begin
                        if (cmd_clear) begin
                            // Clear-overrun command does nothing else
                            overrun_reg <= 1'b0;
                        end else if (cmd_fill && !rect_empty) begin
                            state_reg     <= ST_FILL;
                            cur_x_reg     <= x_reg;
                            cur_y_reg     <= y_reg;
                            x_start_reg   <= x_reg;
                            x_last_reg    <= 7'(x_end - 8'd1);
                            y_last_reg    <= 7'(y_end - 8'd1);
                            swap_pend_reg <= cmd_swap;
                            row_base_reg  <= row_base_start;
                            fb_addr_reg   <= start_addr;
                            fb_data_reg   <= color_reg;
                        end else if (cmd_swap) begin
                            state_reg <= ST_SWAP;
                        end
                    end
                end

                ST_FILL: begin
                    if (cmd_wr) begin
                        overrun_reg <= 1'b1;
                    end
                    if (!fb_we_reg) begin
                        // First FILL cycle only arms the request
                        fb_we_reg <= 1'b1;
                    end else if (FB_READY) begin
                        if (last_cell) begin
                            fb_we_reg <= 1'b0;
                            state_reg <= swap_pend_reg ? ST_SWAP : ST_IDLE;
                        end else if (cur_x_reg == x_last_reg) begin
                            cur_x_reg    <= x_start_reg;
                            cur_y_reg    <= cur_y_reg + 7'd1;
                            row_base_reg <= row_base_reg + ROW_STEP;
                            fb_addr_reg  <= row_base_reg + ROW_STEP + ADDR_W'(x_start_reg);
                        end else begin
                            cur_x_reg   <= cur_x_reg + 7'd1;
                            fb_addr_reg <= fb_addr_reg + ADDR_W'(1);
                        end
                    end
                end

                ST_SWAP: begin
                    if (cmd_wr) begin
                        overrun_reg <= 1'b1;
                    end
                    if (!fb_swap_reg) begin
                        fb_swap_reg <= 1'b1;
                    end else begin
                        fb_swap_reg <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign STATUS  = {overrun_reg, (state_reg != ST_IDLE)};
    assign FB_WE   = fb_we_reg;
    assign FB_ADDR = fb_addr_reg;
    assign FB_DATA = fb_data_reg;
    assign FB_SWAP = fb_swap_reg;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Scoreboard bench for fb_rect_fill: the stimulus pushes expected cell
// writes into a queue and a negedge monitor pops and compares each
// accepted transfer, also watching stall stability and swap pulses.
module tb_fb_rect_fill;

    localparam int ADDR_W = 13;

    logic              CLK_SYS = 1'b0;
    logic              RESET;
    logic              REG_WE;
    logic [2:0]        REG_ADDR;
    logic [6:0]        REG_DATA;
    logic [1:0]        STATUS;
    logic              FB_WE;
    logic [ADDR_W-1:0] FB_ADDR;
    logic [2:0]        FB_DATA;
    logic              FB_READY;
    logic              FB_SWAP;

    fb_rect_fill #(
        .FB_WIDTH (80),
        .FB_HEIGHT(60),
        .ADDR_W   (ADDR_W)
    ) dut (
        .CLK_SYS (CLK_SYS),
        .RESET   (RESET),
        .REG_WE  (REG_WE),
        .REG_ADDR(REG_ADDR),
        .REG_DATA(REG_DATA),
        .STATUS  (STATUS),
        .FB_WE   (FB_WE),
        .FB_ADDR (FB_ADDR),
        .FB_DATA (FB_DATA),
        .FB_READY(FB_READY),
        .FB_SWAP (FB_SWAP)
    );

    always #5 CLK_SYS = ~CLK_SYS;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   swap_count = 0;

    logic              prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr  = '0;
    logic [2:0]        prev_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int addr, input int data);
        exp_t e;
        e.addr = ADDR_W'(addr);
        e.data = 3'(data);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK_SYS);
        #1;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [6:0] d);
        REG_WE   = 1'b1;
        REG_ADDR = a;
        REG_DATA = d;
        tick();
        REG_WE   = 1'b0;
    endtask

    task automatic set_rect(input int x, input int y, input int w, input int h, input int c);
        reg_write(3'd0, 7'(x));
        reg_write(3'd1, 7'(y));
        reg_write(3'd2, 7'(w));
        reg_write(3'd3, 7'(h));
        reg_write(3'd4, 7'(c));
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (STATUS[0] && n < limit) begin
            tick();
            n++;
        end
        total++;
        if (STATUS[0]) begin
            bad++;
            $display("FAIL %s_timeout actual=busy after %0d cycles required=idle", name, limit);
        end
    endtask

    // Monitor: one line per accepted transfer, compared against the queue
    always @(negedge CLK_SYS) begin
        if (FB_SWAP) begin
            swap_count++;
            $display("swap pulse t=%0t", $time);
        end
        if (FB_WE) begin
            check("swap_we_overlap", {31'd0, FB_SWAP}, 32'd0);
            check("addr_range", {31'd0, (FB_ADDR < 13'd4800)}, 32'd1);
        end
        if (prev_stall) begin
            check("stall_we", {31'd0, FB_WE}, 32'd1);
            check("stall_addr", 32'(FB_ADDR), 32'(prev_addr));
            check("stall_data", 32'(FB_DATA), 32'(prev_data));
        end
        if (FB_WE && FB_READY && !RESET) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write actual=addr %0d data %0d required=no write", FB_ADDR, FB_DATA);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("xfer addr=%0d data=%0d expect addr=%0d data=%0d", FB_ADDR, FB_DATA, e.addr, e.data);
                check("xfer_addr", 32'(FB_ADDR), 32'(e.addr));
                check("xfer_data", 32'(FB_DATA), 32'(e.data));
            end
        end
        prev_stall = FB_WE && !FB_READY && !RESET;
        prev_addr  = FB_ADDR;
        prev_data  = FB_DATA;
    end

    initial begin
        int we_cycles;
        int swaps_before;

        RESET    = 1'b1;
        REG_WE   = 1'b0;
        REG_ADDR = '0;
        REG_DATA = '0;
        FB_READY = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_fb_we", {31'd0, FB_WE}, 32'd0);
        check("rst_fb_swap", {31'd0, FB_SWAP}, 32'd0);
        check("rst_fb_addr", 32'(FB_ADDR), 32'd0);
        check("rst_fb_data", 32'(FB_DATA), 32'd0);
        check("rst_status", 32'(STATUS), 32'd0);
        RESET = 1'b0;
        tick();

        // Basic 3x2 fill at (2,3), colour 5
        set_rect(2, 3, 3, 2, 5);
        push_exp(242, 5); push_exp(243, 5); push_exp(244, 5);
        push_exp(322, 5); push_exp(323, 5); push_exp(324, 5);
        reg_write(3'd5, 7'h01);
        check("fill_busy_rise", {31'd0, STATUS[0]}, 32'd1);
        check("fill_we_latency", {31'd0, FB_WE}, 32'd0);
        we_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!STATUS[0]) break;
            if (FB_WE) we_cycles++;
        end
        check("fill_we_cycles", 32'(we_cycles), 32'd6);
        check("fill_busy_fall", {31'd0, STATUS[0]}, 32'd0);
        check("fill_we_drop", {31'd0, FB_WE}, 32'd0);
        check("fill_pending", 32'(exp_q.size()), 32'd0);

        // Clipping at the bottom-right corner
        set_rect(78, 59, 10, 10, 3);
        push_exp(4798, 3); push_exp(4799, 3);
        reg_write(3'd5, 7'h01);
        wait_idle("clip", 100);
        tick();
        check("clip_pending", 32'(exp_q.size()), 32'd0);

        // Empty rectangles: X off-screen, then zero width
        set_rect(80, 5, 3, 3, 1);
        reg_write(3'd5, 7'h01);
        check("empty_x_busy", {31'd0, STATUS[0]}, 32'd0);
        repeat (3) tick();
        check("empty_x_busy_later", {31'd0, STATUS[0]}, 32'd0);
        set_rect(5, 5, 0, 3, 1);
        reg_write(3'd5, 7'h01);
        check("empty_w_busy", {31'd0, STATUS[0]}, 32'd0);
        repeat (3) tick();

        // Empty fill with swap: pulse two cycles after the CMD write
        swaps_before = swap_count;
        reg_write(3'd5, 7'h03);
        check("swap_early", {31'd0, FB_SWAP}, 32'd0);
        tick();
        check("swap_pulse", {31'd0, FB_SWAP}, 32'd1);
        tick();
        check("swap_end", {31'd0, FB_SWAP}, 32'd0);
        check("swap_idle", {31'd0, STATUS[0]}, 32'd0);
        repeat (2) tick();
        check("swap_count", 32'(swap_count - swaps_before), 32'd1);

        // 4x4 fill under random backpressure
        set_rect(10, 20, 4, 4, 6);
        for (int yy = 20; yy < 24; yy++)
            for (int xx = 10; xx < 14; xx++)
                push_exp(yy * 80 + xx, 6);
        reg_write(3'd5, 7'h01);
        for (int n = 0; n < 300 && STATUS[0]; n++) begin
            FB_READY = 1'($urandom_range(0, 1));
            tick();
        end
        FB_READY = 1'b1;
        wait_idle("bp", 10);
        tick();
        check("bp_pending", 32'(exp_q.size()), 32'd0);

        // Overrun and mid-fill colour change
        set_rect(0, 0, 8, 1, 2);
        for (int xx = 0; xx < 8; xx++) push_exp(xx, 2);
        reg_write(3'd5, 7'h01);
        reg_write(3'd4, 7'd7);
        reg_write(3'd5, 7'h01);
        check("ovr_status_busy", 32'(STATUS), 32'd3);
        wait_idle("ovr", 100);
        check("ovr_status_idle", 32'(STATUS), 32'd2);
        check("ovr_pending", 32'(exp_q.size()), 32'd0);
        reg_write(3'd5, 7'h40);
        check("ovr_clear", 32'(STATUS), 32'd0);
        repeat (2) tick();
        check("ovr_clear_no_start", 32'(STATUS), 32'd0);

        // Reset after three transfers of a 10-cell fill with swap pending
        set_rect(0, 1, 10, 1, 4);
        push_exp(80, 4); push_exp(81, 4); push_exp(82, 4);
        swaps_before = swap_count;
        reg_write(3'd5, 7'h03);
        repeat (4) tick();
        FB_READY = 1'b0;
        RESET    = 1'b1;
        tick();
        check("rst_mid_we", {31'd0, FB_WE}, 32'd0);
        check("rst_mid_status", 32'(STATUS), 32'd0);
        check("rst_mid_addr", 32'(FB_ADDR), 32'd0);
        RESET    = 1'b0;
        FB_READY = 1'b1;
        repeat (4) tick();
        check("rst_mid_no_swap", 32'(swap_count - swaps_before), 32'd0);
        check("rst_mid_pending", 32'(exp_q.size()), 32'd0);

        // Fresh fill after the reset
        set_rect(1, 2, 2, 2, 1);
        push_exp(161, 1); push_exp(162, 1); push_exp(241, 1); push_exp(242, 1);
        reg_write(3'd5, 7'h01);
        check("post_rst_busy", {31'd0, STATUS[0]}, 32'd1);
        wait_idle("post_rst", 100);
        tick();
        check("post_rst_pending", 32'(exp_q.size()), 32'd0);
        check("post_rst_status", 32'(STATUS), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
